// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction cache and hands
// each fetched instruction to decode through a valid/ready register.
//
// state     | meaning
// ----------+------------------------------------------------------------
// BOOT      | first cycle after reset, cache not yet requested
// FETCH     | issuing sequential fetches while decode can accept
// MISS_WAIT | cache refilling; pc frozen, miss cycles counted
module fetch_stage #(
    parameter int                  ARCH_LEN = 32,
    parameter int                  INST_LEN = 32,
    parameter logic [ARCH_LEN-1:0] RESET_PC = 'h0000_1000,
    parameter int                  PC_STEP  = 4,
    parameter int                  CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ARCH_LEN-1:0] icache_addr,
    output logic                icache_enable,
    input  logic [INST_LEN-1:0] icache_instr,
    input  logic                icache_miss,
    input  logic                redirect_valid,
    input  logic [ARCH_LEN-1:0] redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INST_LEN-1:0] dec_instr,
    output logic [ARCH_LEN-1:0] dec_pc,
    output logic                misaligned,
    output logic [CNT_W-1:0]    miss_cycles
);

    localparam logic [1:0] S_BOOT      = 2'd0;
    localparam logic [1:0] S_FETCH     = 2'd1;
    localparam logic [1:0] S_MISS_WAIT = 2'd2;

    logic [1:0]          state;
    logic [ARCH_LEN-1:0] pc;
    logic                can_accept;
    logic                fire;
    logic                redirect_taken;

    assign can_accept     = ~dec_valid | dec_ready;
    assign icache_enable  = (state == S_FETCH) & can_accept & ~redirect_valid;
    assign icache_addr    = pc;
    assign fire           = icache_enable & ~icache_miss;
    // Redirects arriving before the first fetch are dropped.
    assign redirect_taken = redirect_valid & (state != S_BOOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            dec_valid   <= 1'b0;
            dec_instr   <= '0;
            dec_pc      <= '0;
            misaligned  <= 1'b0;
            miss_cycles <= '0;
        end else begin
            case (state)
                S_BOOT:      state <= S_FETCH;
                S_FETCH:     if (icache_enable & icache_miss) state <= S_MISS_WAIT;
                S_MISS_WAIT: if (!icache_miss) state <= S_FETCH;
                default:     state <= S_BOOT;
            endcase

            if ((state == S_MISS_WAIT) && (miss_cycles != '1))
                miss_cycles <= miss_cycles + CNT_W'(1);

            if (redirect_taken)
                pc <= redirect_pc;
            else if (fire)
                pc <= pc + ARCH_LEN'(PC_STEP);

            if (redirect_taken) begin
                dec_valid <= 1'b0;
            end else if (fire) begin
                dec_valid <= 1'b1;
                dec_instr <= icache_instr;
                dec_pc    <= pc;
            end else if (dec_valid & dec_ready) begin
                dec_valid <= 1'b0;
            end

            if (redirect_taken && (redirect_pc[1:0] != 2'b00))
                misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the cache model returns {addr[15:0], 16'hC0DE}.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] icache_addr;
    logic        icache_enable;
    logic [31:0] icache_instr;
    logic        icache_miss;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        misaligned;
    logic [31:0] miss_cycles;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign icache_instr = {icache_addr[15:0], 16'hC0DE};

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .icache_addr    (icache_addr),
        .icache_enable  (icache_enable),
        .icache_instr   (icache_instr),
        .icache_miss    (icache_miss),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .misaligned     (misaligned),
        .miss_cycles    (miss_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in FETCH at pc=0x1000 with nothing held for decode.
    task automatic do_reset();
        rst = 1'b1; icache_miss = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; dec_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; icache_miss = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; dec_ready = 1'b1;
        step();
        step();
        rst = 1'b0; #1;
        total++; if (dec_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dec_valid); else passed++;
        total++; if (dec_pc !== 32'h0) $display("FAIL rst_dec_pc: got %h want 00000000", dec_pc); else passed++;
        total++; if (dec_instr !== 32'h0) $display("FAIL rst_dec_instr: got %h want 00000000", dec_instr); else passed++;
        total++; if (misaligned !== 1'b0) $display("FAIL rst_misaligned: got %b want 0", misaligned); else passed++;
        total++; if (miss_cycles !== 32'h0) $display("FAIL rst_miss_cycles: got %0d want 0", miss_cycles); else passed++;
        total++; if (icache_addr !== 32'h1000) $display("FAIL rst_addr: got %h want 00001000", icache_addr); else passed++;
        total++; if (icache_enable !== 1'b0) $display("FAIL boot_enable: got %b want 0", icache_enable); else passed++;
        step();
        total++; if (icache_enable !== 1'b1) $display("FAIL fetch_enable: got %b want 1", icache_enable); else passed++;
        total++; if (dec_valid !== 1'b0) $display("FAIL fetch_valid0: got %b want 0", dec_valid); else passed++;
    endtask

    task automatic test_sequential();
        do_reset();
        step();
        total++; if (dec_pc !== 32'h1000 || dec_valid !== 1'b1) $display("FAIL seq_pc0: got %h/%b want 00001000/1", dec_pc, dec_valid); else passed++;
        total++; if (dec_instr !== 32'h1000_C0DE) $display("FAIL seq_instr0: got %h want 1000c0de", dec_instr); else passed++;
        step();
        total++; if (dec_pc !== 32'h1004 || dec_valid !== 1'b1) $display("FAIL seq_pc1: got %h/%b want 00001004/1", dec_pc, dec_valid); else passed++;
        step();
        total++; if (dec_pc !== 32'h1008) $display("FAIL seq_pc2: got %h want 00001008", dec_pc); else passed++;
        total++; if (dec_instr !== 32'h1008_C0DE) $display("FAIL seq_instr2: got %h want 1008c0de", dec_instr); else passed++;
        total++; if (miss_cycles !== 32'h0) $display("FAIL seq_miss_cycles: got %0d want 0", miss_cycles); else passed++;
    endtask

    task automatic test_miss();
        do_reset();
        icache_miss = 1'b1; #1;
        total++; if (icache_enable !== 1'b1) $display("FAIL miss_first_enable: got %b want 1", icache_enable); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (icache_enable !== 1'b0 || icache_addr !== 32'h1000 || dec_valid !== 1'b0)
                $display("FAIL miss_wait_%0d: got en=%b addr=%h valid=%b want en=0 addr=00001000 valid=0", i, icache_enable, icache_addr, dec_valid);
            else passed++;
        end
        step();
        icache_miss = 1'b0; #1;
        total++; if (icache_enable !== 1'b0) $display("FAIL miss_exit_enable: got %b want 0", icache_enable); else passed++;
        total++; if (miss_cycles !== 32'd4) $display("FAIL miss_cycles_4: got %0d want 4", miss_cycles); else passed++;
        step();
        total++; if (miss_cycles !== 32'd5) $display("FAIL miss_cycles_5: got %0d want 5", miss_cycles); else passed++;
        total++; if (icache_enable !== 1'b1 || icache_addr !== 32'h1000) $display("FAIL miss_refetch: got en=%b addr=%h want en=1 addr=00001000", icache_enable, icache_addr); else passed++;
        step();
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h1000) $display("FAIL miss_deliver: got %b/%h want 1/00001000", dec_valid, dec_pc); else passed++;
        total++; if (miss_cycles !== 32'd5) $display("FAIL miss_cycles_hold: got %0d want 5", miss_cycles); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        step();
        dec_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (icache_enable !== 1'b0 || icache_addr !== 32'h1004 || dec_valid !== 1'b1 ||
                         dec_pc !== 32'h1000 || dec_instr !== 32'h1000_C0DE)
                $display("FAIL stall_hold_%0d: got en=%b addr=%h v=%b pc=%h ins=%h want en=0 addr=00001004 v=1 pc=00001000 ins=1000c0de",
                         i, icache_enable, icache_addr, dec_valid, dec_pc, dec_instr);
            else passed++;
            step();
        end
        dec_ready = 1'b1; #1;
        total++; if (icache_enable !== 1'b1 || icache_addr !== 32'h1004) $display("FAIL stall_release: got en=%b addr=%h want en=1 addr=00001004", icache_enable, icache_addr); else passed++;
        step();
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h1004) $display("FAIL stall_next: got %b/%h want 1/00001004", dec_valid, dec_pc); else passed++;
        dec_ready = 1'b1; icache_miss = 1'b1;
        step();
        total++; if (dec_valid !== 1'b0) $display("FAIL drain_clear: got %b want 0", dec_valid); else passed++;
        icache_miss = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h2000; #1;
        total++; if (icache_enable !== 1'b0) $display("FAIL redir_enable: got %b want 0", icache_enable); else passed++;
        step();
        redirect_valid = 1'b0; dec_ready = 1'b1; #1;
        total++; if (dec_valid !== 1'b0) $display("FAIL redir_flush: got %b want 0", dec_valid); else passed++;
        total++; if (icache_addr !== 32'h2000 || misaligned !== 1'b0) $display("FAIL redir_pc: got %h/%b want 00002000/0", icache_addr, misaligned); else passed++;
        step();
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h2000 || dec_instr !== 32'h2000_C0DE)
            $display("FAIL redir_deliver: got %b/%h/%h want 1/00002000/2000c0de", dec_valid, dec_pc, dec_instr);
        else passed++;
        // Would-be fire at 0x2004 is overridden by the redirect.
        redirect_valid = 1'b1; redirect_pc = 32'h2002;
        step();
        redirect_valid = 1'b0; #1;
        total++; if (dec_valid !== 1'b0 || icache_addr !== 32'h2002) $display("FAIL redir_wins: got %b/%h want 0/00002002", dec_valid, icache_addr); else passed++;
        total++; if (misaligned !== 1'b1) $display("FAIL misaligned_set: got %b want 1", misaligned); else passed++;
        redirect_valid = 1'b1; redirect_pc = 32'h2100;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        total++; if (misaligned !== 1'b1) $display("FAIL misaligned_sticky: got %b want 1", misaligned); else passed++;
        total++; if (dec_pc !== 32'h2104) $display("FAIL redir_after: got %h want 00002104", dec_pc); else passed++;
    endtask

    task automatic test_redirect_in_miss();
        do_reset();
        icache_miss = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h3000; #1;
        total++; if (icache_enable !== 1'b0) $display("FAIL rmiss_enable: got %b want 0", icache_enable); else passed++;
        step();
        redirect_valid = 1'b0; #1;
        total++; if (icache_addr !== 32'h3000 || icache_enable !== 1'b0 || dec_valid !== 1'b0)
            $display("FAIL rmiss_wait: got addr=%h en=%b v=%b want addr=00003000 en=0 v=0", icache_addr, icache_enable, dec_valid);
        else passed++;
        step();
        icache_miss = 1'b0; #1;
        total++; if (icache_enable !== 1'b0 || dec_valid !== 1'b0) $display("FAIL rmiss_exit: got en=%b v=%b want en=0 v=0", icache_enable, dec_valid); else passed++;
        step();
        total++; if (icache_enable !== 1'b1 || icache_addr !== 32'h3000 || dec_valid !== 1'b0)
            $display("FAIL rmiss_refetch: got en=%b addr=%h v=%b want en=1 addr=00003000 v=0", icache_enable, icache_addr, dec_valid);
        else passed++;
        step();
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3000 || dec_instr !== 32'h3000_C0DE)
            $display("FAIL rmiss_deliver: got %b/%h/%h want 1/00003000/3000c0de", dec_valid, dec_pc, dec_instr);
        else passed++;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if (dec_pc !== 32'hFFFF_FFFC || icache_addr !== 32'h0) $display("FAIL wrap_top: got %h/%h want fffffffc/00000000", dec_pc, icache_addr); else passed++;
        step();
        total++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0000_C0DE) $display("FAIL wrap_zero: got %h/%h want 00000000/0000c0de", dec_pc, dec_instr); else passed++;
        icache_miss = 1'b1;
        step();
        step();
        total++; if (miss_cycles !== 32'd1 || icache_addr !== 32'h4) $display("FAIL pre_rst_miss: got %0d/%h want 1/00000004", miss_cycles, icache_addr); else passed++;
        rst = 1'b1;
        step();
        total++; if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_instr !== 32'h0 || miss_cycles !== 32'h0 ||
                     misaligned !== 1'b0 || icache_addr !== 32'h1000 || icache_enable !== 1'b0)
            $display("FAIL mid_rst: got v=%b pc=%h ins=%h mc=%0d mis=%b addr=%h en=%b want all reset", dec_valid, dec_pc, dec_instr, miss_cycles, misaligned, icache_addr, icache_enable);
        else passed++;
        rst = 1'b0; icache_miss = 1'b0;
        step();
        total++; if (icache_enable !== 1'b1 || icache_addr !== 32'h1000) $display("FAIL rst_restart: got en=%b addr=%h want en=1 addr=00001000", icache_enable, icache_addr); else passed++;
        step();
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h1000 || miss_cycles !== 32'h0)
            $display("FAIL rst_refetch: got %b/%h/%0d want 1/00001000/0", dec_valid, dec_pc, miss_cycles);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; icache_miss = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; dec_ready = 1'b1;
        test_reset();
        test_sequential();
        test_miss();
        test_stall();
        test_redirect();
        test_redirect_in_miss();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
